mult_div_unit: RTL and testbench

//   Iterative multiply/divide unit with architectural HI/LO registers, directly downstream of RegFile.

---
 rtl/mult_div_unit.sv | 178 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers; WIDTH BUSY cycles per op.
// No queuing: start, WriteHi and WriteLo are only honoured in IDLE, and the PC is stalled on busy.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             WriteHi,
    input  logic             WriteLo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               div_q, div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;

    // Operand magnitudes; op[0] set means unsigned.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign a_neg = ~op[0] & OperandA[WIDTH-1];
    assign b_neg = ~op[0] & OperandB[WIDTH-1];
    assign a_abs = a_neg ? -OperandA : OperandA;
    assign b_abs = b_neg ? -OperandB : OperandB;

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;

    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: dividend bits shift out of acc low half while quotient bits shift in.
    // The trial difference never exceeds WIDTH bits, so its top bit is an exact borrow.
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem, div_quo;

    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo   = {acc_q[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = neg_lo_q ? -mul_acc : mul_acc;
    assign quo_fix  = neg_lo_q ? -div_quo : div_quo;
    assign rem_fix  = neg_hi_q ? -div_rem : div_rem;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_d    = op[1];
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    count_d  = '0;
                    rem_d    = '0;
                    if (op[1]) begin
                        opnd_d = b_abs;
                        acc_d  = {{WIDTH{1'b0}}, a_abs};
                        if (OperandB == '0) begin
                            state_d = S_DONE;
                            dz_d    = 1'b1;
                        end else begin
                            state_d = S_BUSY;
                        end
                    end else begin
                        opnd_d  = a_abs;
                        acc_d   = {{WIDTH{1'b0}}, b_abs};
                        state_d = S_BUSY;
                    end
                end else begin
                    if (WriteHi) hi_d = OperandA;
                    if (WriteLo) lo_d = OperandA;
                end
            end
            S_BUSY: begin
                count_d = count_q + CNT_ONE;
                if (div_q) begin
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], div_quo};
                    rem_d = div_rem;
                end else begin
                    acc_d = mul_acc;
                end
                if (count_q == CNT_LAST) begin
                    state_d = S_DONE;
                    count_d = '0;
                    if (div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                dz_d    = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                dz_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dz_q     <= dz_d;
        end
    end

    assign busy     = (state_q == S_BUSY);
    assign done     = (state_q == S_DONE);
    assign div_zero = dz_q;
    assign Hi       = hi_q;
    assign Lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] OperandA = '0;
    logic [W-1:0] OperandB = '0;
    logic         WriteHi = 1'b0;
    logic         WriteLo = 1'b0;
    logic         busy, done, div_zero;
    logic [W-1:0] Hi, Lo;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .OperandA (OperandA),
        .OperandB (OperandB),
        .WriteHi  (WriteHi),
        .WriteLo  (WriteLo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one op and count BUSY cycles; optionally pokes start/WriteHi/WriteLo at BUSY cycle poke_at.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke_at, output int cnt);
        logic [W-1:0] hi0, lo0;
        @(negedge clock);
        hi0 = Hi;
        lo0 = Lo;
        start = 1'b1;
        op = o;
        OperandA = a;
        OperandB = b;
        @(negedge clock);
        start = 1'b0;
        OperandA = 32'hA5A5_5A5A;
        OperandB = 32'h0000_0003;
        cnt = 0;
        while (busy && cnt < 100) begin
            if (cnt == poke_at) begin
                start = 1'b1;
                WriteHi = 1'b1;
                WriteLo = 1'b1;
                op = 2'b11;
                OperandA = 32'hDEAD_BEEF;
                OperandB = 32'h0000_0001;
            end else begin
                start = 1'b0;
                WriteHi = 1'b0;
                WriteLo = 1'b0;
            end
            cnt++;
            @(negedge clock);
            if (poke_at >= 0 && cnt == poke_at + 1) begin
                check("hold_hi", 64'(Hi), 64'(hi0));
                check("hold_lo", 64'(Lo), 64'(lo0));
            end
        end
        start = 1'b0;
        WriteHi = 1'b0;
        WriteLo = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int cnt,
                                 input logic [W-1:0] eh, input logic [W-1:0] el);
        check({tag, "_lat"}, 64'(cnt), 64'd32);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_dz"}, 64'(div_zero), 64'd0);
        check({tag, "_hi"}, 64'(Hi), 64'(eh));
        check({tag, "_lo"}, 64'(Lo), 64'(el));
        @(negedge clock);
        check({tag, "_done_end"}, 64'(done), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        check("rst_hi", 64'(Hi), 64'd0);
        check("rst_lo", 64'(Lo), 64'd0);
        reset = 1'b0;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, n);
        expect_result("multu_max", n, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, n);
        expect_result("mult_neg", n, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, n);
        expect_result("mult_min", n, 32'h4000_0000, 32'h0000_0000);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, n);
        expect_result("div_neg", n, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(2'b11, 32'd100, 32'd7, -1, n);
        expect_result("divu", n, 32'd2, 32'd14);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, n);
        expect_result("div_wrap", n, 32'h0000_0000, 32'h8000_0000);

        // MTHI / MTLO preset, then divide by zero must leave them untouched.
        @(negedge clock);
        WriteHi = 1'b1;
        OperandA = 32'h11;
        @(negedge clock);
        WriteHi = 1'b0;
        WriteLo = 1'b1;
        OperandA = 32'h22;
        @(negedge clock);
        WriteLo = 1'b0;
        check("mthi", 64'(Hi), 64'h11);
        check("mtlo", 64'(Lo), 64'h22);
        start = 1'b1;
        op = 2'b10;
        OperandA = 32'd5;
        OperandB = 32'd0;
        @(negedge clock);
        start = 1'b0;
        check("dz_done", 64'(done), 64'd1);
        check("dz_flag", 64'(div_zero), 64'd1);
        check("dz_busy", 64'(busy), 64'd0);
        check("dz_hi", 64'(Hi), 64'h11);
        check("dz_lo", 64'(Lo), 64'h22);
        @(negedge clock);
        check("dz_done_end", 64'(done), 64'd0);
        check("dz_flag_end", 64'(div_zero), 64'd0);

        WriteHi = 1'b1;
        WriteLo = 1'b1;
        OperandA = 32'h55;
        @(negedge clock);
        WriteHi = 1'b0;
        WriteLo = 1'b0;
        check("mt_both_hi", 64'(Hi), 64'h55);
        check("mt_both_lo", 64'(Lo), 64'h55);

        // start wins over a simultaneous MTLO.
        WriteLo = 1'b1;
        run_op(2'b01, 32'd6, 32'd7, -1, n);
        expect_result("start_wins", n, 32'd0, 32'd42);

        // Requests during BUSY are dropped; Hi/Lo stay stale until done.
        run_op(2'b01, 32'd5, 32'd6, 10, n);
        expect_result("mid_busy", n, 32'd0, 32'd30);

        // Reset at cycle 10 of a MULTU aborts immediately.
        @(negedge clock);
        start = 1'b1;
        op = 2'b01;
        OperandA = 32'hFFFF_FFFF;
        OperandB = 32'hFFFF_FFFF;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("abort_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(Hi), 64'd0);
        check("abort_lo", 64'(Lo), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        run_op(2'b11, 32'd100, 32'd7, -1, n);
        expect_result("post_rst", n, 32'd2, 32'd14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
